// File: rtl/requantize_pipe.sv
// Two-stage requantizer: cuts a signed sample to Nq significant bits with
// selectable rounding, saturates, and rescales back to full width.
module requantize_pipe #(
   parameter int DIN_W = 18,
   parameter int NQ_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [NQ_W-1:0]  nquant,
   input  logic [1:0]       rmode,
   input  logic [DIN_W-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [DIN_W-1:0] out_data,
   output logic             out_sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] sat_count
);

   localparam logic signed [DIN_W:0] ONE = 1;

   logic                    s2_adv;
   logic                    s1_adv;

   logic [NQ_W-1:0]         nq_eff;
   logic [NQ_W-1:0]         sh_in;
   logic signed [DIN_W-1:0] din_s;
   logic signed [DIN_W-1:0] quot_in;
   logic                    g_in;
   logic                    st_in;

   logic                    s1_valid_q, s1_valid_d;
   logic signed [DIN_W-1:0] s1_quot_q, s1_quot_d;
   logic                    s1_g_q, s1_g_d;
   logic                    s1_st_q, s1_st_d;
   logic [NQ_W-1:0]         s1_sh_q, s1_sh_d;
   logic [NQ_W-1:0]         s1_nq_q, s1_nq_d;
   logic [1:0]              s1_rmode_q, s1_rmode_d;

   logic                    inc;
   logic signed [DIN_W:0]   sum;
   logic signed [DIN_W:0]   maxv;
   logic signed [DIN_W:0]   clip;
   logic                    sat;
   logic [DIN_W-1:0]        res;

   logic                    out_valid_q, out_valid_d;
   logic [DIN_W-1:0]        out_data_q, out_data_d;
   logic                    out_sat_q, out_sat_d;
   logic [CNT_W-1:0]        sat_count_q, sat_count_d;

   assign s2_adv   = !out_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign sat_count = sat_count_q;

   // Stage 1: clamp Nq, split the sample into kept bits, guard and sticky.
   always_comb begin
      nq_eff = nquant;
      if (nquant == '0) begin
         nq_eff = NQ_W'(1);
      end else if (nquant > NQ_W'(DIN_W)) begin
         nq_eff = NQ_W'(DIN_W);
      end
      sh_in   = NQ_W'(DIN_W) - nq_eff;
      din_s   = in_data;
      quot_in = din_s >>> sh_in;
      g_in    = 1'b0;
      st_in   = 1'b0;
      for (int i = 0; i < DIN_W; i++) begin
         if (i + 1 == int'(sh_in)) begin
            g_in = in_data[i];
         end
         if (i + 1 < int'(sh_in)) begin
            st_in = st_in | in_data[i];
         end
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_quot_d  = s1_quot_q;
      s1_g_d     = s1_g_q;
      s1_st_d    = s1_st_q;
      s1_sh_d    = s1_sh_q;
      s1_nq_d    = s1_nq_q;
      s1_rmode_d = s1_rmode_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_quot_d  = quot_in;
            s1_g_d     = g_in;
            s1_st_d    = st_in;
            s1_sh_d    = sh_in;
            s1_nq_d    = nq_eff;
            s1_rmode_d = rmode;
         end
      end
   end

   // Stage 2: round, clamp to the positive limit, rescale.
   always_comb begin
      unique case (s1_rmode_q)
         2'b00:   inc = 1'b0;
         2'b01:   inc = s1_g_q;
         default: inc = s1_g_q & (s1_st_q | s1_quot_q[0]);
      endcase
      sum  = {s1_quot_q[DIN_W-1], s1_quot_q} + {{DIN_W{1'b0}}, inc};
      maxv = (ONE << (s1_nq_q - NQ_W'(1))) - ONE;
      sat  = sum > maxv;
      clip = sat ? maxv : sum;
      res  = clip[DIN_W-1:0] << s1_sh_q;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      sat_count_d = sat_count_q;
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d = res;
            out_sat_d  = sat;
         end
      end
      if (out_valid_q && out_ready && out_sat_q && (sat_count_q != '1)) begin
         sat_count_d = sat_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_quot_q   <= '0;
         s1_g_q      <= 1'b0;
         s1_st_q     <= 1'b0;
         s1_sh_q     <= '0;
         s1_nq_q     <= NQ_W'(1);
         s1_rmode_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         sat_count_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_quot_q   <= s1_quot_d;
         s1_g_q      <= s1_g_d;
         s1_st_q     <= s1_st_d;
         s1_sh_q     <= s1_sh_d;
         s1_nq_q     <= s1_nq_d;
         s1_rmode_q  <= s1_rmode_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         sat_count_q <= sat_count_d;
      end
   end

endmodule

// File: tb/tb_requantize_pipe.sv
// Directed bench for requantize_pipe: rounding modes, saturation,
// Nq clamping, backpressure burst and mid-stream reset.
module tb_requantize_pipe;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  nquant;
   logic [1:0]  rmode;
   logic [17:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] out_data;
   logic        out_sat;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sat_count;

   int n_cmp = 0;
   int n_bad = 0;

   requantize_pipe dut (
      .clock     (clock),
      .reset     (reset),
      .nquant    (nquant),
      .rmode     (rmode),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sat_count (sat_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run_one(input string tag, input logic [4:0] nq,
                          input logic [1:0] rm, input logic [17:0] din,
                          input logic [17:0] exp_d, input logic exp_s);
      nquant    = nq;
      rmode     = rm;
      in_data   = din;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check({tag, "_rdy"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      check({tag, "_lat1"}, 32'(out_valid), 32'd0);
      tick();
      check({tag, "_vld"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, 32'(out_data), 32'(exp_d));
      check({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
      tick();
      check({tag, "_drain"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int sent;
      int recv;
      reset     = 1'b1;
      nquant    = 5'd4;
      rmode     = 2'b00;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      check("rst_vld", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_sat", 32'(out_sat), 32'd0);
      check("rst_cnt", 32'(sat_count), 32'd0);
      check("rst_rdy", 32'(in_ready), 32'd1);

      run_one("he_p05", 5'd4, 2'b10, 18'h02000, 18'h00000, 1'b0);
      run_one("hu_p05", 5'd4, 2'b01, 18'h02000, 18'h04000, 1'b0);
      run_one("tr_p05", 5'd4, 2'b00, 18'h02000, 18'h00000, 1'b0);
      run_one("he_p15", 5'd4, 2'b10, 18'h06000, 18'h08000, 1'b0);
      run_one("he_m05", 5'd4, 2'b11, 18'h3E000, 18'h00000, 1'b0);
      run_one("tr_m05", 5'd4, 2'b00, 18'h3E000, 18'h3C000, 1'b0);
      check("cnt0", 32'(sat_count), 32'd0);
      run_one("hu_sat", 5'd4, 2'b01, 18'h1F000, 18'h1C000, 1'b1);
      check("cnt1", 32'(sat_count), 32'd1);
      run_one("nq18", 5'd18, 2'b10, 18'h2ABCD, 18'h2ABCD, 1'b0);
      run_one("nq0_tr", 5'd0, 2'b00, 18'h30000, 18'h20000, 1'b0);
      run_one("nq0_sat", 5'd0, 2'b01, 18'h10000, 18'h00000, 1'b1);
      check("cnt2", 32'(sat_count), 32'd2);
      run_one("nq31", 5'd31, 2'b00, 18'h12345, 18'h12345, 1'b0);

      // Settings change between back-to-back beats.
      nquant   = 5'd4;
      rmode    = 2'b01;
      in_data  = 18'h02000;
      in_valid = 1'b1;
      tick();
      nquant = 5'd18;
      tick();
      in_valid = 1'b0;
      check("chg_a_vld", 32'(out_valid), 32'd1);
      check("chg_a_data", 32'(out_data), 32'h04000);
      tick();
      check("chg_b_vld", 32'(out_valid), 32'd1);
      check("chg_b_data", 32'(out_data), 32'h02000);
      tick();
      check("chg_drain", 32'(out_valid), 32'd0);

      // Eight-beat burst, downstream stalled in cycles 3..6.
      sent   = 0;
      recv   = 0;
      nquant = 5'd8;
      rmode  = 2'b00;
      for (int c = 0; c < 40 && recv < 8; c++) begin
         in_valid  = (sent < 8);
         in_data   = 18'(((sent + 1) << 10) | 'h3FF);
         out_ready = !(c >= 3 && c <= 6);
         #1;
         if (c >= 3 && c <= 6) begin
            check("burst_full_rdy", 32'(in_ready), 32'd0);
            check("burst_stall_vld", 32'(out_valid), 32'd1);
            check("burst_stall_data", 32'(out_data), 32'((recv + 1) << 10));
         end
         if (out_valid && out_ready) begin
            check("burst_data", 32'(out_data), 32'((recv + 1) << 10));
            recv++;
         end
         if (in_valid && in_ready) sent++;
         tick();
      end
      in_valid = 1'b0;
      check("burst_sent", 32'(sent), 32'd8);
      check("burst_recv", 32'(recv), 32'd8);
      tick();
      check("burst_nodup", 32'(out_valid), 32'd0);

      // Reset with two beats in flight.
      out_ready = 1'b0;
      nquant    = 5'd4;
      rmode     = 2'b01;
      in_data   = 18'h1F000;
      in_valid  = 1'b1;
      tick();
      in_data = 18'h06000;
      tick();
      in_valid = 1'b0;
      check("mid_vld", 32'(out_valid), 32'd1);
      check("mid_cnt", 32'(sat_count), 32'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mrst_vld", 32'(out_valid), 32'd0);
      check("mrst_cnt", 32'(sat_count), 32'd0);
      check("mrst_data", 32'(out_data), 32'd0);
      check("mrst_rdy", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("mrst_flushed", 32'(out_valid), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
